perf_counter_bank: RTL

Parametrised multi-channel performance counter bank for the MNIST BSR accelerator, the successor to the fixed six-counter monitor. It sits beside the CSR block and counts NUM_CH independent event channels with multi-unit increments (e.g. bytes per beat, blocks per pulse). Each measurement is bounded by start/done pulses or by a programmable cycle window. Results are latched into snapshot registers with per-channel overflow flags and read back through a registered indexed port.

---
 rtl/perf_counter_bank.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: multi-channel performance counter bank.
// NUM_CH event channels accumulate multi-unit increments between a start pulse
// and a stop (done pulse or programmable cycle window). At the stop, the results
// and per-channel overflow flags are latched into snapshot registers, which are
// read back through a registered indexed port.
// Optional build macro: PERF_BANK_SAT_EN -- when defined, counters saturate at
// all-ones on overflow; otherwise they wrap modulo 2^CNT_W.
module perf_counter_bank #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int INC_W  = 4,
  localparam int RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_pulse,
  input  logic                    done_pulse,
  input  logic [CNT_W-1:0]        window_len,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*INC_W-1:0] event_inc,
  input  logic [RD_W-1:0]         rd_sel,
  output logic [CNT_W-1:0]        rd_data,
  output logic [CNT_W-1:0]        total_cycles_snap,
  output logic [NUM_CH-1:0]       ovf_flags,
  output logic                    busy,
  output logic                    measurement_done
);

  typedef enum logic [1:0] {IDLE, MEASURING, LATCH} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    run_q [NUM_CH];
  logic [CNT_W-1:0]    run_d [NUM_CH];
  logic [CNT_W-1:0]    snap_q [NUM_CH];
  logic [CNT_W-1:0]    snap_d [NUM_CH];
  logic [NUM_CH-1:0]   run_ovf_q, run_ovf_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]   ovf_flags_q, ovf_flags_d;
  logic [CNT_W-1:0]    run_total_q, run_total_d;
  logic [CNT_W-1:0]    window_q, window_d;
  logic [CNT_W-1:0]    total_snap_q, total_snap_d;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic                meas_done_q, meas_done_d;

  logic [CNT_W-1:0]    ch_next [NUM_CH];
  logic [NUM_CH-1:0]   ch_carry;
  logic [CNT_W-1:0]    total_inc;
  logic [CNT_W-1:0]    total_next;
  logic                stop;

  // Per-channel adder: one extra bit catches the carry-out for the overflow flag.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W:0] sum;
    assign sum          = {1'b0, run_q[gi]} + (CNT_W+1)'(event_inc[gi*INC_W +: INC_W]);
    assign ch_carry[gi] = sum[CNT_W];
`ifdef PERF_BANK_SAT_EN
    assign ch_next[gi]  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    assign ch_next[gi]  = sum[CNT_W-1:0];
`endif
  end

  // Cycle counter increment; total_inc is the wrapped value used for the window compare.
`ifdef PERF_BANK_SAT_EN
  logic total_carry;
  assign {total_carry, total_inc} = {1'b0, run_total_q} + (CNT_W+1)'(1);
  assign total_next = total_carry ? '1 : total_inc;
`else
  assign total_inc  = run_total_q + CNT_W'(1);
  assign total_next = total_inc;
`endif

  // Stop on done or when this cycle completes the programmed window.
  assign stop = done_pulse || ((window_q != '0) && (total_inc == window_q));

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        run_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      run_ovf_q    <= '0;
      ch_en_q      <= '0;
      ovf_flags_q  <= '0;
      run_total_q  <= '0;
      window_q     <= '0;
      total_snap_q <= '0;
      rd_data_q    <= '0;
      meas_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      snap_q       <= snap_d;
      run_ovf_q    <= run_ovf_d;
      ch_en_q      <= ch_en_d;
      ovf_flags_q  <= ovf_flags_d;
      run_total_q  <= run_total_d;
      window_q     <= window_d;
      total_snap_q <= total_snap_d;
      rd_data_q    <= rd_data_d;
      meas_done_q  <= meas_done_d;
    end
  end

  // Next-state logic: start only from IDLE, stop only from MEASURING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_pulse) state_d = MEASURING;
      MEASURING: if (stop)        state_d = LATCH;
      LATCH:                      state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath next values: clear/capture on start, accumulate while measuring, snapshot on latch.
  always_comb begin
    run_d        = run_q;
    snap_d       = snap_q;
    run_ovf_d    = run_ovf_q;
    ch_en_d      = ch_en_q;
    ovf_flags_d  = ovf_flags_q;
    run_total_d  = run_total_q;
    window_d     = window_q;
    total_snap_d = total_snap_q;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          for (int i = 0; i < NUM_CH; i++) run_d[i] = '0;
          run_ovf_d   = '0;
          run_total_d = '0;
          window_d    = window_len;
          ch_en_d     = ch_en;
        end
      end
      MEASURING: begin
        run_total_d = total_next;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_en_q[i]) begin
            run_d[i] = ch_next[i];
            if (ch_carry[i]) run_ovf_d[i] = 1'b1;
          end
        end
      end
      LATCH: begin
        snap_d       = run_q;
        total_snap_d = run_total_q;
        ovf_flags_d  = run_ovf_q;
      end
      default: ;
    endcase
  end

  // Readout mux: out-of-range selects return zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == RD_W'(i)) rd_data_d = snap_q[i];
    end
  end

  // Outputs derived from state: busy outside IDLE, done pulse the cycle after LATCH.
  always_comb begin
    busy        = (state_q != IDLE);
    meas_done_d = (state_q == LATCH);
  end

  assign rd_data           = rd_data_q;
  assign total_cycles_snap = total_snap_q;
  assign ovf_flags         = ovf_flags_q;
  assign measurement_done  = meas_done_q;

endmodule
